// File: rtl/vec_pkg.sv
// Shared vector-datapath constants and types, used by the vector ALU and the
// writeback unit.
package vec_pkg;

  localparam int DATA_WIDTH = 16;  // Q7.8 signed element
  localparam int LANES      = 16;
  localparam int ADDR_WIDTH = 16;
  localparam int LANE_W     = $clog2(LANES);

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/vector_writeback_unit_if.sv
// Result-bus / data-memory / status bundle between vector execute, the
// writeback unit and data memory.
interface vector_writeback_unit_if #(
  parameter int DATA_WIDTH = vec_pkg::DATA_WIDTH,
  parameter int LANES      = vec_pkg::LANES,
  parameter int ADDR_WIDTH = vec_pkg::ADDR_WIDTH
);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_data [LANES];
  logic        [LANES-1:0]      in_V;
  logic        [LANES-1:0]      in_Z;
  logic        [LANES-1:0]      in_mask;
  logic        [ADDR_WIDTH-1:0] base_addr;

  logic                         mem_stall;
  logic                         mem_we;
  logic        [ADDR_WIDTH-1:0] mem_addr;
  logic        [DATA_WIDTH-1:0] mem_wdata;

  logic                         done;
  logic                         v_any;
  logic                         z_all;

  // Upstream/environment side: drives the result vector and the memory stall.
  modport master (
    output in_valid, in_data, in_V, in_Z, in_mask, base_addr, mem_stall,
    input  in_ready, mem_we, mem_addr, mem_wdata, done, v_any, z_all
  );

  // Writeback unit side.
  modport slave (
    input  in_valid, in_data, in_V, in_Z, in_mask, base_addr, mem_stall,
    output in_ready, mem_we, mem_addr, mem_wdata, done, v_any, z_all
  );

endinterface

// File: rtl/vector_flag_reduce.sv
// Reduces per-lane overflow/zero flags over the enabled lanes into
// vector-level summaries. Purely combinational.
module vector_flag_reduce #(
  parameter int LANES = vec_pkg::LANES
) (
  input  logic [LANES-1:0] v,
  input  logic [LANES-1:0] z,
  input  logic [LANES-1:0] mask,
  output logic             v_any,
  output logic             z_all
);

  // Disabled lanes are neutral: they never raise v_any and never clear z_all,
  // so an empty mask yields z_all=1.
  assign v_any = |(v & mask);
  assign z_all = &(z | ~mask);

endmodule

// File: rtl/vector_writeback_unit.sv
// Captures one vector ALU result and serialises its enabled lanes into the
// scalar data-memory write port, one lane per cycle, then reports flags.
module vector_writeback_unit #(
  parameter int DATA_WIDTH = vec_pkg::DATA_WIDTH,
  parameter int LANES      = vec_pkg::LANES,
  parameter int ADDR_WIDTH = vec_pkg::ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  vector_writeback_unit_if.slave   bus
);

  import vec_pkg::*;

  typedef logic [$clog2(LANES)-1:0] lane_idx_t;
  localparam lane_idx_t LAST_LANE = lane_idx_t'(LANES - 1);

  wb_state_e state_q, state_d;
  lane_idx_t cnt_q, cnt_d;
  lane_idx_t next_lane;

  logic signed [DATA_WIDTH-1:0] data_q [LANES];
  logic [LANES-1:0]      v_q, z_q, mask_q;
  logic [ADDR_WIDTH-1:0] base_q;

  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  v_any_q, z_all_q;
  logic                  v_any_c, z_all_c;
  logic                  capture, flags_load;

  assign next_lane = cnt_q + lane_idx_t'(1);

  // The handshake cycle itself loads lane 0 straight from the input bus, so
  // the registered write port presents lane 0 in the very next cycle.
  always_comb begin
    // NOTE: every signal gets a default before the case; a path that leaves
    // one unassigned would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    capture    = 1'b0;
    flags_load = 1'b0;

    case (state_q)
      IDLE: begin
        we_d = 1'b0;
        if (bus.in_valid) begin
          capture = 1'b1;
          cnt_d   = '0;
          we_d    = bus.in_mask[0];
          addr_d  = bus.base_addr;
          wdata_d = bus.in_data[0];
          state_d = (bus.in_mask != '0) ? WRITE : DONE;
        end
      end

      WRITE: begin
        // A stall keeps all defaults, freezing the counter and write port.
        if (!bus.mem_stall) begin
          if (cnt_q == LAST_LANE) begin
            we_d    = 1'b0;
            state_d = DONE;
          end else begin
            cnt_d   = next_lane;
            we_d    = mask_q[next_lane];
            addr_d  = base_q + ADDR_WIDTH'(next_lane);
            wdata_d = data_q[next_lane];
          end
        end
      end

      DONE: begin
        flags_load = 1'b1;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      v_any_q <= 1'b0;
      z_all_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (flags_load) begin
        v_any_q <= v_any_c;
        z_all_q <= z_all_c;
      end
    end
  end

  // NOTE: the capture bank has no reset; it is only read after a handshake
  // has loaded it, and leaving it unreset keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (capture) begin
      data_q <= bus.in_data;
      v_q    <= bus.in_V;
      z_q    <= bus.in_Z;
      mask_q <= bus.in_mask;
      base_q <= bus.base_addr;
    end
  end

  vector_flag_reduce #(.LANES(LANES)) u_flag_reduce (
    .v     (v_q),
    .z     (z_q),
    .mask  (mask_q),
    .v_any (v_any_c),
    .z_all (z_all_c)
  );

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.v_any     = v_any_q;
  assign bus.z_all     = z_all_q;

endmodule

// File: tb/tb_vector_writeback_unit.sv
// Scoreboard bench for vector_writeback_unit: expected memory writes are
// queued at stimulus time and matched against the write port.
module tb_vector_writeback_unit;

  import vec_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vector_writeback_unit_if bus ();

  vector_writeback_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  logic [DATA_WIDTH-1:0] vd [LANES];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Every accepted write must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (bus.mem_we === 1'b1 && bus.mem_stall === 1'b0) begin
      check("write_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("wr_addr", bus.mem_addr, e.addr);
        check("wr_data", bus.mem_wdata, e.data);
      end
    end
  end

  task automatic wait_ready(input string name);
    int budget = 0;
    while (bus.in_ready !== 1'b1 && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    check({name, "_ready"}, bus.in_ready, 1);
  endtask

  task automatic drive_vector(input logic [15:0] base, input logic [15:0] v,
                              input logic [15:0] z, input logic [15:0] mask,
                              input int last_lane);
    for (int i = 0; i < LANES; i++) begin
      bus.in_data[i] = vd[i];
      if (mask[i] && i <= last_lane) sb.push_back({base + 16'(i), vd[i]});
    end
    bus.in_V      = v;
    bus.in_Z      = z;
    bus.in_mask   = mask;
    bus.base_addr = base;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    // Scramble the bus so a unit reading live inputs instead of its capture is exposed.
    bus.in_valid  = 1'b0;
    bus.in_mask   = ~mask;
    bus.base_addr = 16'hDEAD;
    bus.in_V      = ~v;
    bus.in_Z      = ~z;
    for (int i = 0; i < LANES; i++) bus.in_data[i] = ~vd[i];
  endtask

  task automatic run_vector(input string name, input logic [15:0] base,
                            input logic [15:0] v, input logic [15:0] z,
                            input logic [15:0] mask, input int stall_at,
                            input int stall_len, input int exp_lat,
                            input logic exp_v, input logic exp_z);
    int e = 0;
    logic [DATA_WIDTH-1:0] stall_data;
    stall_data = (stall_at >= 0) ? vd[stall_at] : '0;
    wait_ready(name);
    drive_vector(base, v, z, mask, LANES - 1);
    while (bus.done !== 1'b1 && e < 64) begin
      if (e == stall_at) bus.mem_stall = 1'b1;
      if (e == stall_at + stall_len) bus.mem_stall = 1'b0;
      if (bus.mem_stall) begin
        check({name, "_stall_we"}, bus.mem_we, 1);
        check({name, "_stall_addr"}, bus.mem_addr, base + 16'(stall_at));
        check({name, "_stall_data"}, bus.mem_wdata, stall_data);
      end
      @(posedge clk); #1;
      e++;
    end
    bus.mem_stall = 1'b0;
    check({name, "_done_lat"}, e, exp_lat);
    @(posedge clk); #1;
    check({name, "_done_pulse"}, bus.done, 0);
    check({name, "_ready_after"}, bus.in_ready, 1);
    check({name, "_v_any"}, bus.v_any, exp_v);
    check({name, "_z_all"}, bus.z_all, exp_z);
    check({name, "_all_written"}, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.mem_stall = 1'b0;
    bus.in_V      = '0;
    bus.in_Z      = '0;
    bus.in_mask   = '0;
    bus.base_addr = '0;
    for (int i = 0; i < LANES; i++) bus.in_data[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_done", bus.done, 0);
    check("rst_v_any", bus.v_any, 0);
    check("rst_z_all", bus.z_all, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full mask, lane i = i.0 in Q7.8.
    for (int i = 0; i < LANES; i++) vd[i] = 16'(i) << 8;
    run_vector("full", 16'h0100, 16'h0000, 16'h0000, 16'hFFFF, -1, 0, 17 - 1, 1'b0, 1'b0);

    // Odd lanes only; the V on lane 2 is masked off.
    for (int i = 0; i < LANES; i++) vd[i] = 16'($urandom);
    run_vector("odd", 16'h0100, 16'h0004, 16'hAAAA, 16'hAAAA, -1, 0, 16, 1'b0, 1'b1);

    // Three stall cycles while lane 5 is presented.
    for (int i = 0; i < LANES; i++) vd[i] = 16'($urandom);
    run_vector("stall", 16'h0300, 16'h0010, 16'h0000, 16'hFFFF, 5, 3, 19, 1'b1, 1'b0);

    // Address wrap; overflowing lane 3 is masked.
    for (int i = 0; i < LANES; i++) vd[i] = 16'($urandom);
    run_vector("wrap_fff7", 16'hFFF8, 16'h0008, 16'hFFFF, 16'hFFF7, -1, 0, 16, 1'b0, 1'b1);

    // Empty mask: no writes, done right after the handshake.
    run_vector("mask0", 16'h0500, 16'hFFFF, 16'h0000, 16'h0000, -1, 0, 0, 1'b0, 1'b1);

    // Same wrap, lane 3 now enabled.
    for (int i = 0; i < LANES; i++) vd[i] = 16'($urandom);
    run_vector("wrap_ffff", 16'hFFF8, 16'h0008, 16'hFFFF, 16'hFFFF, -1, 0, 16, 1'b1, 1'b1);

    // Reset while lane 7 is presented: lanes 0..7 reach memory, nothing after.
    for (int i = 0; i < LANES; i++) vd[i] = 16'($urandom);
    wait_ready("rst_mid");
    drive_vector(16'h0200, 16'h0000, 16'h0000, 16'hFFFF, 7);
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_mem_we", bus.mem_we, 0);
    check("rst_mid_in_ready", bus.in_ready, 1);
    check("rst_mid_done", bus.done, 0);
    check("rst_mid_v_any", bus.v_any, 0);
    check("rst_mid_z_all", bus.z_all, 0);
    check("rst_mid_written", sb.size(), 0);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end

    // A fresh vector after the abandoned one is written in full.
    for (int i = 0; i < LANES; i++) vd[i] = 16'($urandom);
    run_vector("after_rst", 16'h0400, 16'h0000, 16'hFFFF, 16'hFFFF, -1, 0, 16, 1'b0, 1'b1);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vector_writeback_unit.md
# vector_writeback_unit

Sequential consumer of the 16-lane Q7.8 vector ALU result bus. Captures one full vector result plus per-lane V/Z flags through a valid/ready handshake, then serialises the enabled lanes into the scalar 16-bit data-memory write port, one element per cycle, at consecutive addresses. It also produces vector-level overflow and zero summary flags for the control unit. It sits between the vector execute stage and data memory, in the writeback stage.

## Interface
- DATA_WIDTH, 16, element width (Q7.8 signed)
- LANES, 16, number of vector lanes
- ADDR_WIDTH, 16, data-memory word address width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  result vector and flags are valid
- in_ready  out  1  unit can capture a vector
- in_data  in  LANES x DATA_WIDTH  unpacked array of lane results, signed
- in_V  in  LANES x 1  per-lane overflow flags
- in_Z  in  LANES x 1  per-lane zero flags
- in_mask  in  LANES  lane write-enable mask; bit i enables lane i
- base_addr  in  ADDR_WIDTH  word address for lane 0
- mem_stall  in  1  memory cannot accept a write this cycle
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_WIDTH  write address
- mem_wdata  out  DATA_WIDTH  write data
- done  out  1  one-cycle pulse when a vector has finished writing
- v_any  out  1  OR of in_V over enabled lanes of the last finished vector
- z_all  out  1  AND of in_Z over enabled lanes of the last finished vector; 1 when mask is 0

## Operation
- FSM states: IDLE, WRITE, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, register in_data, in_V, in_Z, in_mask and base_addr; clear lane counter to 0. Go to WRITE if mask!=0, otherwise go to DONE.
- WRITE: in_ready=0. Each non-stalled cycle handles the lane at the counter, then increments the counter.
  - Enabled lane: mem_we=1, mem_addr=base_addr+lane (modulo 2^ADDR_WIDTH, wraps), mem_wdata=captured element.
  - Masked lane: mem_we=0 and the cycle is still consumed, so the schedule is fixed.
  - After lane LANES-1 is handled, go to DONE.
- DONE: done=1 for exactly one cycle. Load v_any and z_all from the captured vector. Go to IDLE.
- mem_stall=1 during WRITE: counter frozen; mem_we, mem_addr and mem_wdata held stable. A write counts only on a cycle with mem_we=1 and mem_stall=0. mem_stall is ignored in IDLE and DONE.
- v_any and z_all hold their values until the next DONE.
- rst at any point, including mid-WRITE: return to IDLE. Issue no further writes. The partially written vector is abandoned.

## Timing
- Reset values: in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0, v_any=0, z_all=0, counter=0, state IDLE.
- mem_we, mem_addr and mem_wdata are registered outputs.
- Handshake accepted at edge t:
  - lane 0 is presented in cycle t+1;
  - lane k is presented in cycle t+1+k plus the number of stall cycles so far;
  - done is high in cycle t+1+LANES+stalls;
  - in_ready returns to 1 in the cycle after done.
- With no stalls, throughput is one vector per LANES+2 cycles.
- mask==0: done is high in cycle t+1, with no writes.
- Inputs other than those captured at the handshake are don't-care outside IDLE.

## Structure
- Shared package vec_pkg holds:
  - DATA_WIDTH, LANES and ADDR_WIDTH defaults;
  - the FSM state enum (IDLE, WRITE, DONE);
  - the lane-index type, $clog2(LANES) bits.
- The vector ALU uses the same package for its lane constants.
- Sub-module vector_flag_reduce: combinational reduction of the masked V and Z vectors to v_any and z_all. It is instantiated once and its outputs are registered at DONE.
- Everything else (FSM, counter, capture registers, address adder) lives in vector_writeback_unit.

## Test plan
- Full mask, no stall: base_addr=0x0100, lane i = i*0x0100 (i.0 in Q7.8) -> 16 writes to 0x0100..0x010F with data 0x0000..0x0F00 on consecutive cycles; done at t+17.
- Mask 0xAAAA: writes only on odd lanes (0x0101, 0x0103, ...); mem_we=0 on even-lane cycles; done still at t+17.
- Stall: mem_stall=1 for 3 cycles while lane 5 is presented -> lane 5 address and data held, no lane skipped or duplicated; done at t+20.
- Flags and wrap: base_addr=0xFFF8, in_V set only on lane 3, all in_Z=1, mask=0xFFF7 -> addresses wrap 0xFFF8..0x0007; v_any=0, z_all=1. Repeat with mask 0xFFFF -> v_any=1.
- mask=0 -> no writes; done at t+1; z_all=1, v_any=0.
- rst asserted during lane 7 -> mem_we=0 next cycle; in_ready=1, done=0, v_any=0, z_all=0; a new vector is then accepted and written fully.
